// File: rtl/multicycle_control_unit.sv
// Multicycle MIPS control FSM: FETCH/DECODE/EXECUTE/MEM/WB sequencing with memory wait,
// bounded-wait timeout and illegal-opcode reporting. Optional BNE support via MCU_BNE_EN.
module multicycle_control_unit #(
    parameter int unsigned OPCODE_W   = 6,
    parameter int unsigned ALU_OP_W   = 2,
    parameter int unsigned WAIT_LIMIT = 15
) (
    input  logic                clk,
    input  logic                arst_n,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                zero,
    input  logic                mem_ready,
    output logic                pc_write,
    output logic                pc_write_cond,
    output logic                i_or_d,
    output logic                ir_write,
    output logic                mem_read,
    output logic                mem_write,
    output logic                mem_2_reg,
    output logic                reg_dst,
    output logic                reg_write,
    output logic                alu_src_a,
    output logic [1:0]          alu_src_b,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic [1:0]          pc_source,
    output logic                illegal_op,
    output logic                mem_timeout,
`ifdef MCU_BNE_EN
    output logic                branch_ne,
`endif
    output logic                halted
);

    localparam int unsigned CntW = (WAIT_LIMIT > 0) ? $clog2(WAIT_LIMIT + 1) : 1;
    localparam logic [CntW-1:0] WaitMax = CntW'(WAIT_LIMIT);

    localparam logic [OPCODE_W-1:0] OpRType = OPCODE_W'('h00);
    localparam logic [OPCODE_W-1:0] OpAddi  = OPCODE_W'('h08);
    localparam logic [OPCODE_W-1:0] OpBeq   = OPCODE_W'('h04);
    localparam logic [OPCODE_W-1:0] OpJump  = OPCODE_W'('h02);
    localparam logic [OPCODE_W-1:0] OpLw    = OPCODE_W'('h23);
    localparam logic [OPCODE_W-1:0] OpSw    = OPCODE_W'('h2B);
`ifdef MCU_BNE_EN
    localparam logic [OPCODE_W-1:0] OpBne   = OPCODE_W'('h05);
`endif

    localparam logic [ALU_OP_W-1:0] AluAdd   = ALU_OP_W'(0);
    localparam logic [ALU_OP_W-1:0] AluSub   = ALU_OP_W'(1);
    localparam logic [ALU_OP_W-1:0] AluRType = ALU_OP_W'(2);

    typedef enum logic [3:0] {
        StReset, StFetch, StDecode, StExecR, StRWb, StExecI, StIWb, StMemAddr,
        StMemRd, StMemWb, StMemWr, StBranch, StJump, StHalt, StBranchNe
    } state_e;

    state_e          r_state_q, r_state_d;
    logic [CntW-1:0] r_wait_q, r_wait_d;
    logic            w_waiting;
    logic            w_at_limit;

    // Branch decision is resolved in the datapath.
    logic w_unused_zero;
    assign w_unused_zero = zero;

    assign w_waiting  = r_state_q inside {StFetch, StMemRd, StMemWr};
    assign w_at_limit = (WAIT_LIMIT != 0) && (r_wait_q == WaitMax);

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_state_q <= StReset;
            r_wait_q  <= '0;
        end else begin
            r_state_q <= r_state_d;
            r_wait_q  <= r_wait_d;
        end
    end

    // Any state change clears the counter; only wait states ever hold with mem_ready=0.
    always_comb begin
        r_wait_d = r_wait_q;
        if (r_state_d != r_state_q) begin
            r_wait_d = '0;
        end else if (w_waiting && !mem_ready && (r_wait_q != {CntW{1'b1}})) begin
            r_wait_d = r_wait_q + CntW'(1);
        end
    end

    always_comb begin
        r_state_d     = r_state_q;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        i_or_d        = 1'b0;
        ir_write      = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        mem_2_reg     = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'd0;
        alu_op        = AluAdd;
        pc_source     = 2'd0;
        illegal_op    = 1'b0;
        mem_timeout   = 1'b0;
        halted        = 1'b0;
`ifdef MCU_BNE_EN
        branch_ne     = 1'b0;
`endif
        case (r_state_q)
            StReset: r_state_d = StFetch;
            StFetch: begin
                mem_read  = 1'b1;
                alu_src_b = 2'd1;
                if (mem_ready) begin
                    ir_write  = 1'b1;
                    pc_write  = 1'b1;
                    r_state_d = StDecode;
                end else if (w_at_limit) begin
                    mem_timeout = 1'b1;
                    r_state_d   = StHalt;
                end
            end
            StDecode: begin
                alu_src_b = 2'd3;
                case (opcode)
                    OpRType:    r_state_d = StExecR;
                    OpAddi:     r_state_d = StExecI;
                    OpBeq:      r_state_d = StBranch;
                    OpJump:     r_state_d = StJump;
                    OpLw, OpSw: r_state_d = StMemAddr;
`ifdef MCU_BNE_EN
                    OpBne:      r_state_d = StBranchNe;
`endif
                    default: begin
                        illegal_op = 1'b1;
                        r_state_d  = StFetch;
                    end
                endcase
            end
            StExecR: begin
                alu_src_a = 1'b1;
                alu_op    = AluRType;
                r_state_d = StRWb;
            end
            StRWb: begin
                reg_dst   = 1'b1;
                reg_write = 1'b1;
                r_state_d = StFetch;
            end
            StExecI: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'd2;
                r_state_d = StIWb;
            end
            StIWb: begin
                reg_write = 1'b1;
                r_state_d = StFetch;
            end
            StMemAddr: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'd2;
                r_state_d = (opcode == OpLw) ? StMemRd : StMemWr;
            end
            StMemRd: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
                if (mem_ready) begin
                    r_state_d = StMemWb;
                end else if (w_at_limit) begin
                    mem_timeout = 1'b1;
                    r_state_d   = StHalt;
                end
            end
            StMemWb: begin
                reg_write = 1'b1;
                mem_2_reg = 1'b1;
                r_state_d = StFetch;
            end
            StMemWr: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
                if (mem_ready) begin
                    r_state_d = StFetch;
                end else if (w_at_limit) begin
                    mem_timeout = 1'b1;
                    r_state_d   = StHalt;
                end
            end
            StBranch: begin
                alu_src_a     = 1'b1;
                alu_op        = AluSub;
                pc_source     = 2'd1;
                pc_write_cond = 1'b1;
                r_state_d     = StFetch;
            end
`ifdef MCU_BNE_EN
            StBranchNe: begin
                alu_src_a     = 1'b1;
                alu_op        = AluSub;
                pc_source     = 2'd1;
                pc_write_cond = 1'b1;
                branch_ne     = 1'b1;
                r_state_d     = StFetch;
            end
`endif
            StJump: begin
                pc_write  = 1'b1;
                pc_source = 2'd2;
                r_state_d = StFetch;
            end
            StHalt: halted = 1'b1;
            default: r_state_d = StFetch;
        endcase
    end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Self-checking bench for multicycle_control_unit (WAIT_LIMIT=4): directed vector table,
// hand-written timeout/async-reset sequences, and random stimulus against a plan-queue model.
module tb_multicycle_control_unit;

    localparam int unsigned Limit = 4;

    logic       clk = 1'b0;
    logic       arst_n = 1'b0;
    logic [5:0] opcode = 6'h00;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       pc_write, pc_write_cond, i_or_d, ir_write, mem_read, mem_write;
    logic       mem_2_reg, reg_dst, reg_write, alu_src_a;
    logic [1:0] alu_src_b, alu_op, pc_source;
    logic       illegal_op, mem_timeout, halted;
`ifdef MCU_BNE_EN
    logic       branch_ne;
`endif

    multicycle_control_unit #(
        .OPCODE_W   (6),
        .ALU_OP_W   (2),
        .WAIT_LIMIT (Limit)
    ) dut (
        .clk           (clk),
        .arst_n        (arst_n),
        .opcode        (opcode),
        .zero          (zero),
        .mem_ready     (mem_ready),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .i_or_d        (i_or_d),
        .ir_write      (ir_write),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .mem_2_reg     (mem_2_reg),
        .reg_dst       (reg_dst),
        .reg_write     (reg_write),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .alu_op        (alu_op),
        .pc_source     (pc_source),
        .illegal_op    (illegal_op),
        .mem_timeout   (mem_timeout),
`ifdef MCU_BNE_EN
        .branch_ne     (branch_ne),
`endif
        .halted        (halted)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       pcw, pcwc, iord, irw, mrd, mwr, m2r, rdst, rw, srca;
        logic [1:0] srcb, aluop, pcsrc;
        logic       ill, tmo, hlt;
    } ctrl_t;

    ctrl_t act;
    assign act = {pc_write, pc_write_cond, i_or_d, ir_write, mem_read, mem_write, mem_2_reg,
                  reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source, illegal_op,
                  mem_timeout, halted};

    typedef enum int {SRst, SFetch, SDec, SExR, SRwb, SExI, SIwb, SAddr, SRd, SMwb, SWr,
                      SBr, SJ, SHalt} step_e;

    typedef struct {
        logic [5:0] op;
        logic       rdy;
        step_e      step;
        logic       ill;
        logic       tmo;
        string      tag;
    } vec_t;

    vec_t  vecs[$];
    int    n_cmp = 0;
    int    n_bad = 0;

    // Reference model: current step, steps still planned for this instruction, wait count.
    step_e m_step;
    step_e m_plan[$];
    int    m_wait;
    logic [5:0] m_op;

    function automatic ctrl_t base(step_e s);
        ctrl_t c = '0;
        case (s)
            SFetch: begin c.mrd = 1; c.srcb = 2'd1; end
            SDec:   c.srcb = 2'd3;
            SExR:   begin c.srca = 1; c.aluop = 2'd2; end
            SRwb:   begin c.rdst = 1; c.rw = 1; end
            SExI, SAddr: begin c.srca = 1; c.srcb = 2'd2; end
            SIwb:   c.rw = 1;
            SRd:    begin c.mrd = 1; c.iord = 1; end
            SMwb:   begin c.rw = 1; c.m2r = 1; end
            SWr:    begin c.mwr = 1; c.iord = 1; end
            SBr:    begin c.srca = 1; c.aluop = 2'd1; c.pcsrc = 2'd1; c.pcwc = 1; end
            SJ:     begin c.pcw = 1; c.pcsrc = 2'd2; end
            SHalt:  c.hlt = 1;
            default: c = '0;
        endcase
        return c;
    endfunction

    function automatic ctrl_t expect_out(step_e s, logic rdy, logic ill, logic tmo);
        ctrl_t c = base(s);
        if (s == SFetch && rdy) begin
            c.pcw = 1;
            c.irw = 1;
        end
        c.ill = ill;
        c.tmo = tmo;
        return c;
    endfunction

    function automatic bit legal(logic [5:0] op);
        return op inside {6'h00, 6'h08, 6'h04, 6'h02, 6'h23, 6'h2B};
    endfunction

    function automatic bit is_wait(step_e s);
        return s inside {SFetch, SRd, SWr};
    endfunction

    task automatic check(input string tag, input ctrl_t exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b want %b (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Entered and left at posedge+1; outputs compared on the falling edge.
    task automatic apply(input logic [5:0] op, input logic rdy, input ctrl_t exp,
                         input string tag);
        opcode    = op;
        mem_ready = rdy;
        @(negedge clk);
        check(tag, exp);
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_step = SRst;
        m_wait = 0;
        m_plan.delete();
    endtask

    task automatic do_reset(input string tag);
        arst_n = 1'b0;
        #2;
        check(tag, '0);
        @(posedge clk);
        #1;
        arst_n = 1'b1;
        model_reset();
    endtask

    function automatic step_e next_planned();
        if (m_plan.size() != 0) return m_plan.pop_front();
        return SFetch;
    endfunction

    function automatic bit model_timeout(logic rdy);
        return is_wait(m_step) && !rdy && (Limit > 0) && (m_wait == Limit);
    endfunction

    task automatic model_advance(input logic [5:0] op, input logic rdy);
        step_e nxt = m_step;
        case (m_step)
            SRst:  nxt = SFetch;
            SHalt: nxt = SHalt;
            SFetch, SRd, SWr: begin
                if (rdy) nxt = (m_step == SFetch) ? SDec : next_planned();
                else if (model_timeout(rdy)) nxt = SHalt;
            end
            SDec: begin
                m_op = op;
                m_plan.delete();
                case (op)
                    6'h00: begin m_plan.push_back(SExR); m_plan.push_back(SRwb); end
                    6'h08: begin m_plan.push_back(SExI); m_plan.push_back(SIwb); end
                    6'h04: m_plan.push_back(SBr);
                    6'h02: m_plan.push_back(SJ);
                    6'h23: begin m_plan.push_back(SAddr); m_plan.push_back(SRd);
                                 m_plan.push_back(SMwb); end
                    6'h2B: begin m_plan.push_back(SAddr); m_plan.push_back(SWr); end
                    default: m_plan.delete();
                endcase
                nxt = next_planned();
            end
            default: nxt = next_planned();
        endcase
        if (nxt != m_step) m_wait = 0;
        else if (is_wait(m_step) && !rdy) m_wait++;
        m_step = nxt;
    endtask

    task automatic vec(input logic [5:0] op, input logic rdy, input step_e s, input logic ill,
                       input logic tmo, input string tag);
        vec_t v;
        v.op = op; v.rdy = rdy; v.step = s; v.ill = ill; v.tmo = tmo; v.tag = tag;
        vecs.push_back(v);
    endtask

    initial begin
        int    stall;
        int    halt_cycles;
        logic  rdy;
        logic [5:0] op;
        logic [5:0] pick [8];

        // Directed program run straight out of reset; opcodes in non-sampled cycles vary.
        vec(6'h00, 1, SRst,   0, 0, "rst_cycle");
        vec(6'h00, 1, SFetch, 0, 0, "r_fetch");
        vec(6'h00, 1, SDec,   0, 0, "r_dec");
        vec(6'h3F, 1, SExR,   0, 0, "r_exec");
        vec(6'h2B, 1, SRwb,   0, 0, "r_wb");
        vec(6'h23, 1, SFetch, 0, 0, "lw_fetch");
        vec(6'h23, 1, SDec,   0, 0, "lw_dec");
        vec(6'h23, 1, SAddr,  0, 0, "lw_addr");
        vec(6'h00, 1, SRd,    0, 0, "lw_rd");
        vec(6'h00, 1, SMwb,   0, 0, "lw_wb");
        vec(6'h2B, 1, SFetch, 0, 0, "sw_fetch");
        vec(6'h2B, 1, SDec,   0, 0, "sw_dec");
        vec(6'h2B, 1, SAddr,  0, 0, "sw_addr");
        vec(6'h2B, 1, SWr,    0, 0, "sw_wr");
        vec(6'h00, 0, SFetch, 0, 0, "fwait1");
        vec(6'h00, 0, SFetch, 0, 0, "fwait2");
        vec(6'h00, 0, SFetch, 0, 0, "fwait3");
        vec(6'h08, 1, SFetch, 0, 0, "fwait_go");
        vec(6'h08, 1, SDec,   0, 0, "i_dec");
        vec(6'h08, 1, SExI,   0, 0, "i_exec");
        vec(6'h08, 1, SIwb,   0, 0, "i_wb");
        vec(6'h3F, 1, SFetch, 0, 0, "ill_fetch");
        vec(6'h3F, 1, SDec,   1, 0, "ill_dec");
        vec(6'h04, 1, SFetch, 0, 0, "beq_fetch");
        vec(6'h04, 1, SDec,   0, 0, "beq_dec");
        vec(6'h3F, 1, SBr,    0, 0, "beq_branch");
        vec(6'h02, 1, SFetch, 0, 0, "j_fetch");
        vec(6'h02, 1, SDec,   0, 0, "j_dec");
        vec(6'h02, 1, SJ,     0, 0, "j_jump");
`ifndef MCU_BNE_EN
        vec(6'h05, 1, SFetch, 0, 0, "bne_fetch");
        vec(6'h05, 1, SDec,   1, 0, "bne_illegal");
`endif
        vec(6'h00, 0, SFetch, 0, 0, "end_fetch");

        #1;
        do_reset("reset_state");
        foreach (vecs[i]) begin
            apply(vecs[i].op, vecs[i].rdy,
                  expect_out(vecs[i].step, vecs[i].rdy, vecs[i].ill, vecs[i].tmo), vecs[i].tag);
        end

        // Timeout in MEM_RD on the fifth wait cycle, then sticky HALT.
        do_reset("reset_before_tmo");
        apply(6'h23, 1, expect_out(SRst, 1, 0, 0), "tmo_rst");
        apply(6'h23, 1, expect_out(SFetch, 1, 0, 0), "tmo_fetch");
        apply(6'h23, 1, expect_out(SDec, 1, 0, 0), "tmo_dec");
        apply(6'h23, 1, expect_out(SAddr, 1, 0, 0), "tmo_addr");
        for (int i = 0; i < 4; i++) apply(6'h23, 0, expect_out(SRd, 0, 0, 0), "tmo_wait");
        apply(6'h23, 0, expect_out(SRd, 0, 0, 1), "tmo_pulse");
        for (int i = 0; i < 3; i++) apply(6'h00, 1, expect_out(SHalt, 1, 0, 0), "halt_hold");
        do_reset("halt_cleared");

        // Ready on the limit cycle wins over the timeout.
        apply(6'h23, 1, expect_out(SRst, 1, 0, 0), "lim_rst");
        apply(6'h23, 1, expect_out(SFetch, 1, 0, 0), "lim_fetch");
        apply(6'h23, 1, expect_out(SDec, 1, 0, 0), "lim_dec");
        apply(6'h23, 1, expect_out(SAddr, 1, 0, 0), "lim_addr");
        for (int i = 0; i < 4; i++) apply(6'h23, 0, expect_out(SRd, 0, 0, 0), "lim_wait");
        apply(6'h23, 1, expect_out(SRd, 1, 0, 0), "lim_ready");
        apply(6'h23, 1, expect_out(SMwb, 1, 0, 0), "lim_wb");
        apply(6'h23, 1, expect_out(SFetch, 1, 0, 0), "lim_next_fetch");

        // Asynchronous reset in the middle of a MEM_WR wait.
        do_reset("reset_before_async");
        apply(6'h2B, 1, expect_out(SRst, 1, 0, 0), "as_rst");
        apply(6'h2B, 1, expect_out(SFetch, 1, 0, 0), "as_fetch");
        apply(6'h2B, 1, expect_out(SDec, 1, 0, 0), "as_dec");
        apply(6'h2B, 1, expect_out(SAddr, 1, 0, 0), "as_addr");
        apply(6'h2B, 0, expect_out(SWr, 0, 0, 0), "as_wr_wait");
        mem_ready = 1'b0;
        #1;
        check("as_before_assert", expect_out(SWr, 0, 0, 0));
        arst_n = 1'b0;
        #1;
        check("as_outputs_cleared", '0);
        @(posedge clk);
        #1;
        arst_n = 1'b1;
        apply(6'h2B, 0, expect_out(SRst, 0, 0, 0), "as_reset_cycle");
        apply(6'h2B, 0, expect_out(SFetch, 0, 0, 0), "as_fetch_after");

        // Random traffic against the model.
        pick = '{6'h00, 6'h08, 6'h04, 6'h02, 6'h23, 6'h2B, 6'h3F, 6'h11};
        do_reset("reset_before_random");
        stall = 0;
        halt_cycles = 0;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            if ((m_step == SHalt && halt_cycles >= 2) || $urandom_range(0, 199) == 0) begin
                do_reset("rand_reset");
                halt_cycles = 0;
            end
            if (m_step == SDec) begin
                op = pick[$urandom_range(0, 7)];
                if ($urandom_range(0, 7) == 0) op = 6'($urandom());
            end else if (m_step == SAddr) begin
                op = m_op;
            end else begin
                op = 6'($urandom());
            end
            if (stall > 0) begin
                rdy = 1'b0;
                stall--;
            end else begin
                rdy = ($urandom_range(0, 9) < 7);
                if ($urandom_range(0, 24) == 0) stall = $urandom_range(3, 6);
            end
            apply(op, rdy,
                  expect_out(m_step, rdy, (m_step == SDec) && !legal(op), model_timeout(rdy)),
                  "random");
            if (m_step == SHalt) halt_cycles++;
            model_advance(op, rdy);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
